// File: rtl/fft16_pkg.sv
// Shared types and constants for the 16-point FFT frame sequencer.
// The bitrev4() helper maps a natural index to its decimation-in-time slot.
package fft16_pkg;

    localparam int FFT_PTS = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_COMMIT,
        ST_START,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] i_v);
        return {i_v[0], i_v[1], i_v[2], i_v[3]};
    endfunction

endpackage

// File: rtl/fft16_idx_cnt.sv
// 4-bit frame index counter with increment enable.
// o_wrap flags the increment that rolls the count from the last point back to 0.
module fft16_idx_cnt
    import fft16_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_cnt,
    output logic             o_wrap
);

    logic [IDX_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = i_inc && (r_cnt == IDX_W'(FFT_PTS - 1));

endmodule

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer: fill 16 samples, commit bank, start FFT, wait for done, drain 16 results.
// Define FFT16_BITREV_EN to write staging slots in bit-reversed order.
module fft16_frame_ctrl
    import fft16_pkg::*;
#(
    parameter int N        = 16,
    parameter int WAIT_MAX = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [IDX_W-1:0] o_wr_idx,
    output logic             o_wr_en,
    output logic             o_bank_we,
    output logic             o_fft_start,
    input  logic             i_fft_done,
    output logic [IDX_W-1:0] o_rd_idx,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             o_busy,
    output logic             o_err
);

    localparam int WAIT_W = $clog2(WAIT_MAX);

    // N sizes the external sample datapath; this block only sequences indices.
    if (N < 1) begin : g_bad_width
    end

    state_t             r_state;
    state_t             w_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_err;
    logic               w_wr_inc;
    logic               w_rd_inc;
    logic               w_wr_wrap;
    logic               w_rd_wrap;
    logic               w_timeout;
    logic [IDX_W-1:0]   w_wr_cnt;
    logic [IDX_W-1:0]   w_rd_cnt;

    fft16_idx_cnt u_wr_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (w_wr_inc),
        .o_cnt  (w_wr_cnt),
        .o_wrap (w_wr_wrap)
    );

    fft16_idx_cnt u_rd_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (w_rd_inc),
        .o_cnt  (w_rd_cnt),
        .o_wrap (w_rd_wrap)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt       = r_state;
        s_ready     = 1'b0;
        o_bank_we   = 1'b0;
        o_fft_start = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        o_busy      = 1'b1;
        w_wr_inc    = 1'b0;
        w_rd_inc    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_FILL: begin
                s_ready  = 1'b1;
                o_busy   = 1'b0;
                w_wr_inc = s_valid;
                if (w_wr_wrap) w_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                o_bank_we = 1'b1;
                w_nxt     = ST_START;
            end
            ST_START: begin
                o_fft_start = 1'b1;
                w_nxt       = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the expiry clock still wins over the timeout.
                if (i_fft_done) begin
                    w_nxt = ST_DRAIN;
                end else if (r_wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
                    w_timeout = 1'b1;
                    w_nxt     = ST_FILL;
                end
            end
            ST_DRAIN: begin
                m_valid  = 1'b1;
                m_last   = (w_rd_cnt == IDX_W'(FFT_PTS - 1));
                w_rd_inc = m_ready;
                if (w_rd_wrap) w_nxt = ST_FILL;
            end
            default: w_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_START) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign o_wr_en  = w_wr_inc;
    assign o_rd_idx = w_rd_cnt;
    assign o_err    = r_err;

`ifdef FFT16_BITREV_EN
    assign o_wr_idx = bitrev4(w_wr_cnt);
`else
    assign o_wr_idx = w_wr_cnt;
`endif

endmodule
